// File: rtl/sbox_pkg.sv
// Shared types and constants for the nibble substitution layer sequencer.
package sbox_pkg;

  localparam int unsigned NIB_W       = 4;
  localparam int unsigned TBL_ENTRIES = 16;
  localparam int unsigned TBL_W       = NIB_W * TBL_ENTRIES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry k holds k: a transparent layer.
  localparam logic [TBL_W-1:0] IDENTITY_TBL = 64'hFEDC_BA98_7654_3210;

  // PRESENT S-box, entry k on bits [4k+3:4k].
  localparam logic [TBL_W-1:0] PRESENT_TBL  = 64'h2174_8FE3_DA09_B65C;

endpackage

// File: rtl/sbox_tbl_regs.sv
// 16 x 4-bit substitution table, reset to identity, presented as a flat bus.
module sbox_tbl_regs
  import sbox_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [NIB_W-1:0]     addr,
  input  logic [NIB_W-1:0]     data,
  output logic [TBL_W-1:0]     tbl_o
);

  // Table storage; the caller gates we so the table only changes between words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_o <= IDENTITY_TBL;
    end else if (we) begin
      tbl_o[int'(addr)*NIB_W +: NIB_W] <= data;
    end
  end

endmodule

// File: rtl/sbox_layer_seq.sv
// Walks a data word one nibble per cycle through an external 16:1 LUT mux
// and assembles the substituted result word.
module sbox_layer_seq
  import sbox_pkg::*;
#(
  parameter  int unsigned NIBBLES = 16,
  localparam int unsigned DATA_W  = NIB_W * NIBBLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [NIB_W-1:0]  cfg_addr,
  input  logic [NIB_W-1:0]  cfg_data,
  input  logic              cfg_lock,
  output logic              locked,
  output logic [TBL_W-1:0]  tbl_o,
  output logic [NIB_W-1:0]  sel_o,
  input  logic [NIB_W-1:0]  lut_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned        CNT_W    = 4;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   data_q;
  logic                accept;
  logic [NIB_W-1:0]    sel_nxt;
  logic                tbl_we;

  // Table writes only between words and only while unlocked.
  assign tbl_we = cfg_we && (state == IDLE) && !locked;

  sbox_tbl_regs u_tbl (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we),
    .addr  (cfg_addr),
    .data  (cfg_data),
    .tbl_o (tbl_o)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, accept strobe and the select value for the next cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sel_nxt   = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
          sel_nxt   = in_data[NIB_W-1:0];
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) begin
          state_nxt = DONE;
        end else begin
          sel_nxt = data_q[(int'(cnt) + 1) * NIB_W +: NIB_W];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      data_q    <= '0;
      out_data  <= '0;
      sel_o     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
    end else begin
      locked    <= locked | cfg_lock;
      sel_o     <= sel_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      if (accept) begin
        data_q <= in_data;
        cnt    <= '0;
      end
      if (state == RUN) begin
        out_data[int'(cnt)*NIB_W +: NIB_W] <= lut_i;
        cnt <= (cnt == LAST_CNT) ? '0 : CNT_W'(cnt + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Directed bench for sbox_layer_seq; the bench itself models the 16:1 LUT mux.
module tb_sbox_layer_seq;
  import sbox_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic        cfg_lock;
  logic        locked;
  logic [63:0] tbl_o;
  logic [3:0]  sel_o;
  logic [3:0]  lut_i;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [63:0] PRES_TBL = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] IDEN_TBL = 64'hFEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  // External LUT mux the block is built to drive.
  assign lut_i = tbl_o[int'(sel_o)*4 +: 4];

  sbox_layer_seq #(.NIBBLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_lock  (cfg_lock),
    .locked    (locked),
    .tbl_o     (tbl_o),
    .sel_o     (sel_o),
    .lut_i     (lut_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Accept edge E0; returns with the block in RUN.
  task automatic accept_word(input string tag, input logic [63:0] d);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_notready"}, 64'(in_ready), 64'd0);
    chk({tag, "_sel0"}, 64'(sel_o), 64'(d[3:0]));
  endtask

  // E1..E16, checking the exact cycle out_valid appears.
  task automatic finish_run(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 15; i++) tick();
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_seldone"}, 64'(sel_o), 64'd0);
  endtask

  task automatic drain(input string tag, input logic [63:0] exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_vlow"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    chk({tag, "_kept"}, out_data, exp);
  endtask

  task automatic run_word(input string tag, input logic [63:0] d, input logic [63:0] exp);
    accept_word(tag, d);
    finish_run(tag, exp);
    drain(tag, exp);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_lock = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_tbl", tbl_o, IDEN_TBL);
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_odata", out_data, 64'd0);
    chk("rst_sel", 64'(sel_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Identity table is transparent
    run_word("ident", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // Load PRESENT S-box
    wr(4'h0, 4'hC); wr(4'h1, 4'h5); wr(4'h2, 4'h6); wr(4'h3, 4'hB);
    wr(4'h4, 4'h9); wr(4'h5, 4'h0); wr(4'h6, 4'hA); wr(4'h7, 4'hD);
    wr(4'h8, 4'h3); wr(4'h9, 4'hE); wr(4'hA, 4'hF); wr(4'hB, 4'h8);
    wr(4'hC, 4'h4); wr(4'hD, 4'h7); wr(4'hE, 4'h1); wr(4'hF, 4'h2);
    chk("load_tbl", tbl_o, PRES_TBL);
    run_word("pres1", 64'h0123_4567_89AB_CDEF, 64'hC56B_90AD_3EF8_4712);
    run_word("pres0", 64'h0, 64'hCCCC_CCCC_CCCC_CCCC);

    // Back-pressure in DONE
    accept_word("hold", 64'hFFFF_0000_FFFF_0000);
    finish_run("hold", 64'h2222_CCCC_2222_CCCC);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_v", 64'(out_valid), 64'd1);
      chk("hold_d", out_data, 64'h2222_CCCC_2222_CCCC);
      chk("hold_r", 64'(in_ready), 64'd0);
    end
    drain("hold", 64'h2222_CCCC_2222_CCCC);
    chk("hold_busy", 64'(busy), 64'd0);

    // Table write during RUN is dropped
    accept_word("runwr", 64'h0);
    tick(); tick();
    wr(4'h0, 4'h0);
    chk("runwr_tbl", tbl_o, PRES_TBL);
    for (int i = 0; i < 12; i++) tick();
    chk("runwr_early", 64'(out_valid), 64'd0);
    tick();
    chk("runwr_valid", 64'(out_valid), 64'd1);
    chk("runwr_data", out_data, 64'hCCCC_CCCC_CCCC_CCCC);
    drain("runwr", 64'hCCCC_CCCC_CCCC_CCCC);

    // Lock blocks writes; reset clears lock and restores identity
    cfg_lock = 1'b1; tick(); cfg_lock = 1'b0;
    chk("lock_set", 64'(locked), 64'd1);
    wr(4'h0, 4'hF);
    chk("lock_tbl", tbl_o, PRES_TBL);
    chk("lock_stay", 64'(locked), 64'd1);
    do_reset();
    chk("unlock", 64'(locked), 64'd0);
    chk("unlock_tbl", tbl_o, IDEN_TBL);

    // Write in the same edge the lock first rises is honoured
    cfg_lock = 1'b1;
    wr(4'h3, 4'hA);
    cfg_lock = 1'b0;
    chk("lockedge_tbl", tbl_o, 64'hFEDC_BA98_7654_A210);
    chk("lockedge_lk", 64'(locked), 64'd1);
    do_reset();

    // Write and accept on the same edge: word sees the new entry
    cfg_we = 1'b1; cfg_addr = 4'hF; cfg_data = 4'h0;
    accept_word("simul", 64'h0123_4567_89AB_CDEF);
    cfg_we = 1'b0;
    finish_run("simul", 64'h0123_4567_89AB_CDE0);
    drain("simul", 64'h0123_4567_89AB_CDE0);

    // Reset mid-RUN discards the partial result
    accept_word("midrst", 64'h1111_2222_3333_4444);
    for (int i = 0; i < 7; i++) tick();
    chk("midrst_busy", 64'(busy), 64'd1);
    do_reset();
    chk("midrst_busy0", 64'(busy), 64'd0);
    chk("midrst_oval", 64'(out_valid), 64'd0);
    chk("midrst_odata", out_data, 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_sel", 64'(sel_o), 64'd0);
    chk("midrst_tbl", tbl_o, IDEN_TBL);
    run_word("after", 64'hDEAD_BEEF_0BAD_F00D, 64'hDEAD_BEEF_0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
